// File: rtl/keypad_number_entry.sv
// Collects keypad digits into a signed BCD entry buffer for the display, then
// converts it to two's-complement binary and hands it to the CPU via valid/ready.
module keypad_number_entry #(
   parameter int MAX_DIGITS = 8,
   parameter int WIDTH      = 32
) (
   input  logic                    sys_clk,
   input  logic                    rst_n,
   input  logic                    key_pulse,
   input  logic [5:0]              key_code,
   output logic [WIDTH-1:0]        value,
   output logic                    value_valid,
   input  logic                    value_ready,
   output logic [4*MAX_DIGITS-1:0] disp_bcd,
   output logic [3:0]              disp_count,
   output logic                    disp_neg,
   output logic                    key_drop
);

   typedef enum logic [1:0] {ENTRY, CONV, VALID} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

   state_t                  state;
   logic [WIDTH-1:0]        acc;
   logic [3:0]              idx;

   logic                    low_page;
   logic                    is_digit;
   logic [4*MAX_DIGITS-1:0] bcd_shl;
   logic [4*MAX_DIGITS-1:0] bcd_shr;
   logic [3:0]              conv_digit;
   logic [WIDTH-1:0]        acc_next;

   // Shifted buffer images and the next conversion step (acc*10 + digit)
   always_comb begin
      low_page   = (key_code[5:4] == 2'b00);
      is_digit   = low_page && (key_code[3:0] <= 4'd9);
      bcd_shl    = disp_bcd << 4;
      bcd_shl[3:0] = key_code[3:0];
      bcd_shr    = disp_bcd >> 4;
      conv_digit = 4'd0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (idx == 4'(i)) conv_digit = disp_bcd[4*i +: 4];
      end
      acc_next   = (acc << 3) + (acc << 1) + WIDTH'(conv_digit);
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state       <= ENTRY;
         acc         <= '0;
         idx         <= '0;
         value       <= '0;
         value_valid <= 1'b0;
         disp_bcd    <= '0;
         disp_count  <= '0;
         disp_neg    <= 1'b0;
         key_drop    <= 1'b0;
      end else begin
         key_drop <= 1'b0;
         case (state)
            ENTRY: begin
               if (key_pulse && is_digit) begin
                  if (disp_count == MAX_CNT) begin
                     key_drop <= 1'b1;
                  end else if (disp_count == 4'd1 && disp_bcd[3:0] == 4'd0) begin
                     disp_bcd[3:0] <= key_code[3:0];
                  end else begin
                     disp_bcd   <= bcd_shl;
                     disp_count <= disp_count + 4'd1;
                  end
               end else if (key_pulse && low_page) begin
                  case (key_code[3:0])
                     4'hA: disp_neg <= ~disp_neg;
                     4'hD: begin
                        disp_bcd   <= '0;
                        disp_count <= '0;
                        disp_neg   <= 1'b0;
                     end
                     // Backspace on an empty buffer only drops the sign
                     4'hE: begin
                        if (disp_count == 4'd0) begin
                           disp_neg <= 1'b0;
                        end else begin
                           disp_bcd   <= bcd_shr;
                           disp_count <= disp_count - 4'd1;
                        end
                     end
                     4'hF: begin
                        if (disp_count != 4'd0) begin
                           acc   <= '0;
                           idx   <= disp_count - 4'd1;
                           state <= CONV;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            CONV: begin
               key_drop <= key_pulse;
               acc      <= acc_next;
               if (idx == 4'd0) begin
                  value       <= disp_neg ? -acc_next : acc_next;
                  value_valid <= 1'b1;
                  state       <= VALID;
               end else begin
                  idx <= idx - 4'd1;
               end
            end
            VALID: begin
               key_drop <= key_pulse;
               if (value_ready) begin
                  value_valid <= 1'b0;
                  disp_bcd    <= '0;
                  disp_count  <= '0;
                  disp_neg    <= 1'b0;
                  state       <= ENTRY;
               end
            end
            default: state <= ENTRY;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_number_entry.sv
// Self-checking bench: a digit-queue model of the entry/convert/handshake behaviour
// is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_keypad_number_entry;

   localparam int MAX_DIGITS = 8;
   localparam int WIDTH      = 32;

   logic                    sys_clk = 1'b0;
   logic                    rst_n;
   logic                    key_pulse;
   logic [5:0]              key_code;
   logic [WIDTH-1:0]        value;
   logic                    value_valid;
   logic                    value_ready;
   logic [4*MAX_DIGITS-1:0] disp_bcd;
   logic [3:0]              disp_count;
   logic                    disp_neg;
   logic                    key_drop;

   int n_compared   = 0;
   int n_mismatched = 0;

   keypad_number_entry #(.MAX_DIGITS(MAX_DIGITS), .WIDTH(WIDTH)) dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .key_pulse   (key_pulse),
      .key_code    (key_code),
      .value       (value),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .disp_bcd    (disp_bcd),
      .disp_count  (disp_count),
      .disp_neg    (disp_neg),
      .key_drop    (key_drop)
   );

   always #5 sys_clk = ~sys_clk;

   // Model: entered digits kept most-significant first, phase 0/1/2 = entry/convert/offer
   int         m_digits[$];
   bit         m_neg;
   int         m_phase;
   int         m_conv_left;
   logic [31:0] m_pending;
   logic [31:0] m_value;
   bit         m_valid;
   bit         m_drop;
   bit         compare_en = 1'b0;
   int         kc;

   function automatic logic [31:0] decimalValue();
      longint v = 0;
      foreach (m_digits[i]) v = v * 10 + m_digits[i];
      if (m_neg) v = -v;
      return v[31:0];
   endfunction

   function automatic logic [31:0] expectedBcd();
      logic [31:0] r = '0;
      int n = m_digits.size();
      for (int i = 0; i < n; i++) r[4*i +: 4] = 4'(m_digits[n-1-i]);
      return r;
   endfunction

   always @(posedge sys_clk) begin
      m_drop = 1'b0;
      kc = int'(key_code);
      if (!rst_n) begin
         m_digits.delete();
         m_neg = 1'b0; m_phase = 0; m_value = '0; m_valid = 1'b0;
         compare_en = 1'b1;
      end else begin
         case (m_phase)
            0: if (key_pulse) begin
               if (kc <= 9) begin
                  if (m_digits.size() >= MAX_DIGITS) m_drop = 1'b1;
                  else if (m_digits.size() == 1 && m_digits[0] == 0) m_digits[0] = kc;
                  else m_digits.push_back(kc);
               end else if (kc == 10) begin
                  m_neg = !m_neg;
               end else if (kc == 13) begin
                  m_digits.delete(); m_neg = 1'b0;
               end else if (kc == 14) begin
                  if (m_digits.size() == 0) m_neg = 1'b0;
                  else void'(m_digits.pop_back());
               end else if (kc == 15 && m_digits.size() > 0) begin
                  m_pending   = decimalValue();
                  m_conv_left = m_digits.size();
                  m_phase     = 1;
               end
            end
            1: begin
               m_drop = key_pulse;
               m_conv_left--;
               if (m_conv_left == 0) begin
                  m_value = m_pending; m_valid = 1'b1; m_phase = 2;
               end
            end
            default: begin
               m_drop = key_pulse;
               if (value_ready) begin
                  m_valid = 1'b0; m_digits.delete(); m_neg = 1'b0; m_phase = 0;
               end
            end
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      if (compare_en) begin
         checkOutput("value", 64'(value), 64'(m_value));
         checkOutput("value_valid", 64'(value_valid), 64'(m_valid));
         checkOutput("disp_bcd", 64'(disp_bcd), 64'(expectedBcd()));
         checkOutput("disp_count", 64'(disp_count), 64'(m_digits.size()));
         checkOutput("disp_neg", 64'(disp_neg), 64'(m_neg));
         checkOutput("key_drop", 64'(key_drop), 64'(m_drop));
      end
   end

   // Inputs are applied at a negedge and held across exactly one rising edge
   task automatic applyStimulus(input logic kp, input logic [5:0] code, input logic rdy);
      key_pulse   = kp;
      key_code    = code;
      value_ready = rdy;
      @(negedge sys_clk);
      key_pulse   = 1'b0;
      key_code    = 6'h1F;
      value_ready = 1'b0;
   endtask

   task automatic pressKey(input logic [5:0] code);
      applyStimulus(1'b1, code, 1'b0);
   endtask

   task automatic waitValid(output int cycles);
      cycles = 0;
      while (!value_valid && cycles < 40) begin
         @(negedge sys_clk);
         cycles++;
      end
      checkOutput("valid_rise", 64'(value_valid), 64'd1);
   endtask

   int lat;

   initial begin
      rst_n = 1'b0; key_pulse = 1'b0; key_code = 6'h1F; value_ready = 1'b0;
      repeat (2) @(negedge sys_clk);
      checkOutput("rst_count", 64'(disp_count), 64'd0);
      checkOutput("rst_valid", 64'(value_valid), 64'd0);
      checkOutput("rst_bcd", 64'(disp_bcd), 64'd0);
      rst_n = 1'b1;

      $display("[TB] scenario 1: positive entry and handshake");
      pressKey(6'h01); pressKey(6'h02); pressKey(6'h03);
      checkOutput("t1_bcd", 64'(disp_bcd[11:0]), 64'h123);
      checkOutput("t1_count", 64'(disp_count), 64'd3);
      pressKey(6'h0F);
      waitValid(lat);
      checkOutput("t1_latency", 64'(lat), 64'd3);
      checkOutput("t1_value", 64'(value), 64'd123);
      repeat (10) @(negedge sys_clk);
      checkOutput("t1_hold", 64'(value_valid), 64'd1);
      applyStimulus(1'b0, 6'h1F, 1'b1);
      checkOutput("t1_ack_valid", 64'(value_valid), 64'd0);
      checkOutput("t1_ack_count", 64'(disp_count), 64'd0);

      $display("[TB] scenario 2: negative entry, ignored codes");
      pressKey(6'h0A); pressKey(6'h04); pressKey(6'h00); pressKey(6'h0B);
      pressKey(6'h09); pressKey(6'h0C); pressKey(6'h06); pressKey(6'h1F);
      checkOutput("t2_neg", 64'(disp_neg), 64'd1);
      checkOutput("t2_bcd", 64'(disp_bcd[15:0]), 64'h4096);
      pressKey(6'h0F);
      waitValid(lat);
      checkOutput("t2_value", 64'(value), 64'hFFFFF000);
      applyStimulus(1'b0, 6'h1F, 1'b1);

      $display("[TB] scenario 3: leading zeros and backspace");
      pressKey(6'h00); pressKey(6'h00);
      checkOutput("t3_count_zeros", 64'(disp_count), 64'd1);
      pressKey(6'h07); pressKey(6'h0E); pressKey(6'h0A); pressKey(6'h0E);
      checkOutput("t3_neg_cleared", 64'(disp_neg), 64'd0);
      checkOutput("t3_count_empty", 64'(disp_count), 64'd0);
      pressKey(6'h05);
      checkOutput("t3_bcd", 64'(disp_bcd), 64'h5);
      pressKey(6'h0F);
      waitValid(lat);
      checkOutput("t3_value", 64'(value), 64'd5);
      applyStimulus(1'b0, 6'h1F, 1'b1);

      $display("[TB] scenario 4: buffer full");
      for (int i = 0; i < 8; i++) pressKey(6'h09);
      pressKey(6'h09);
      checkOutput("t4_drop", 64'(key_drop), 64'd1);
      checkOutput("t4_count", 64'(disp_count), 64'd8);
      pressKey(6'h0F);
      waitValid(lat);
      checkOutput("t4_latency", 64'(lat), 64'd8);
      checkOutput("t4_value", 64'(value), 64'd99999999);
      applyStimulus(1'b0, 6'h1F, 1'b1);

      $display("[TB] scenario 5: keys while busy");
      pressKey(6'h04); pressKey(6'h02); pressKey(6'h0F);
      pressKey(6'h03);
      checkOutput("t5_drop_conv", 64'(key_drop), 64'd1);
      checkOutput("t5_bcd_conv", 64'(disp_bcd[7:0]), 64'h42);
      waitValid(lat);
      pressKey(6'h03);
      checkOutput("t5_drop_valid", 64'(key_drop), 64'd1);
      checkOutput("t5_count_valid", 64'(disp_count), 64'd2);
      applyStimulus(1'b1, 6'h03, 1'b1);
      checkOutput("t5_drop_ack", 64'(key_drop), 64'd1);
      checkOutput("t5_ack_valid", 64'(value_valid), 64'd0);
      checkOutput("t5_ack_count", 64'(disp_count), 64'd0);
      checkOutput("t5_value_kept", 64'(value), 64'd42);

      $display("[TB] scenario 6: reset mid-conversion, empty '#'");
      for (int i = 1; i <= 5; i++) pressKey(6'(i));
      pressKey(6'h0F);
      repeat (2) @(negedge sys_clk);
      rst_n = 1'b0;
      @(negedge sys_clk);
      rst_n = 1'b1;
      checkOutput("t6_count", 64'(disp_count), 64'd0);
      checkOutput("t6_value", 64'(value), 64'd0);
      repeat (10) @(negedge sys_clk);
      checkOutput("t6_no_valid", 64'(value_valid), 64'd0);
      pressKey(6'h0F);
      repeat (3) @(negedge sys_clk);
      checkOutput("t6_empty_hash", 64'(value_valid), 64'd0);
      checkOutput("t6_empty_count", 64'(disp_count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
